// File: rtl/muldiv_wb_pkg.sv
// Shared types and default sizes for the MulDiv writeback buffer.
package muldiv_wb_pkg;

   localparam int MULDIV_XLEN  = 64;
   localparam int MULDIV_TAG_W = 6;
   localparam int MULDIV_DEPTH = 2;

   typedef struct packed {
      logic [MULDIV_TAG_W-1:0] tag;
      logic [MULDIV_XLEN-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/muldiv_wb_fifo.sv
// Ring FIFO with push, pop, flush and occupancy count.
module muldiv_wb_fifo
   import muldiv_wb_pkg::*;
#(
   parameter type entry_t = wb_entry_t,
   parameter int  DEPTH   = MULDIV_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  entry_t                     push_data,
   input  logic                       pop,
   input  logic                       flush,
   output entry_t                     head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the head is only exposed when count is nonzero.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/muldiv_wb_buffer.sv
// MulDiv writeback buffer: pending tag, error flag, result FIFO.
// Define MULDIV_WB_BYPASS_EN for a zero-latency path around an empty FIFO.
module muldiv_wb_buffer
   import muldiv_wb_pkg::*;
#(
   parameter int XLEN  = MULDIV_XLEN,
   parameter int TAG_W = MULDIV_TAG_W,
   parameter int DEPTH = MULDIV_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       io_req_fire,
   input  logic [TAG_W-1:0]           io_req_tag,
   input  logic                       io_kill,
   input  logic                       io_flush,
   input  logic                       io_mul_resp_valid,
   input  logic [XLEN-1:0]            io_mul_resp_data,
   output logic                       io_mul_resp_ready,
   output logic                       io_wb_valid,
   output logic [TAG_W-1:0]           io_wb_tag,
   output logic [XLEN-1:0]            io_wb_data,
   input  logic                       io_wb_ready,
   output logic [$clog2(DEPTH+1)-1:0] io_count,
   output logic                       io_busy,
   output logic                       io_err
);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } entry_t;

   logic             pend_valid_q, pend_valid_d;
   logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
   logic             err_q, err_d;

   logic   resp_hs;
   logic   resp_done;
   logic   enq;
   logic   fire_ok;
   logic   fifo_push;
   logic   fifo_pop;
   logic   fifo_full;
   logic   fifo_empty;
   entry_t fifo_head;
   entry_t new_entry;

   assign resp_hs   = io_mul_resp_valid & io_mul_resp_ready;
   assign resp_done = resp_hs & pend_valid_q;
   assign enq       = resp_done & ~io_kill & ~io_flush;
   // A new request is legal once the old op is retired, killed or flushed.
   assign fire_ok   = ~pend_valid_q | resp_done | io_kill | io_flush;
   assign new_entry = '{tag: pend_tag_q, data: io_mul_resp_data};

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_tag_d   = pend_tag_q;
      err_d        = err_q;
      if (io_req_fire & ~fire_ok) begin
         err_d = 1'b1;
      end
      if (resp_hs & ~pend_valid_q & ~io_kill & ~io_flush) begin
         err_d = 1'b1;
      end
      if (io_req_fire & fire_ok) begin
         pend_valid_d = 1'b1;
         pend_tag_d   = io_req_tag;
      end else if (resp_done | io_kill | io_flush) begin
         pend_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_tag_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_tag_q   <= pend_tag_d;
         err_q        <= err_d;
      end
   end

   assign fifo_pop = io_wb_ready & ~fifo_empty;

`ifdef MULDIV_WB_BYPASS_EN
   logic byp;
   assign byp       = fifo_empty & enq;
   assign fifo_push = enq & ~(byp & io_wb_ready);

   always_comb begin
      io_wb_valid = 1'b0;
      io_wb_tag   = '0;
      io_wb_data  = '0;
      if (!fifo_empty) begin
         io_wb_valid = 1'b1;
         io_wb_tag   = fifo_head.tag;
         io_wb_data  = fifo_head.data;
      end else if (byp) begin
         io_wb_valid = 1'b1;
         io_wb_tag   = new_entry.tag;
         io_wb_data  = new_entry.data;
      end
   end
`else
   assign fifo_push = enq;

   always_comb begin
      io_wb_valid = 1'b0;
      io_wb_tag   = '0;
      io_wb_data  = '0;
      if (!fifo_empty) begin
         io_wb_valid = 1'b1;
         io_wb_tag   = fifo_head.tag;
         io_wb_data  = fifo_head.data;
      end
   end
`endif

   muldiv_wb_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (new_entry),
      .pop       (fifo_pop),
      .flush     (io_flush),
      .head      (fifo_head),
      .count     (io_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign io_mul_resp_ready = ~fifo_full;
   assign io_busy           = pend_valid_q;
   assign io_err            = err_q;

endmodule

// File: tb/tb_muldiv_wb_buffer.sv
// Directed plus random checks of muldiv_wb_buffer against a queue model.
module tb_muldiv_wb_buffer;

   localparam int XLEN  = 64;
   localparam int TAG_W = 6;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             io_req_fire = 1'b0;
   logic [TAG_W-1:0] io_req_tag = '0;
   logic             io_kill = 1'b0;
   logic             io_flush = 1'b0;
   logic             io_mul_resp_valid = 1'b0;
   logic [XLEN-1:0]  io_mul_resp_data = '0;
   logic             io_mul_resp_ready;
   logic             io_wb_valid;
   logic [TAG_W-1:0] io_wb_tag;
   logic [XLEN-1:0]  io_wb_data;
   logic             io_wb_ready = 1'b0;
   logic [CW-1:0]    io_count;
   logic             io_busy;
   logic             io_err;

   always #5 clock = ~clock;

   muldiv_wb_buffer #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .DEPTH (DEPTH)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .io_req_fire       (io_req_fire),
      .io_req_tag        (io_req_tag),
      .io_kill           (io_kill),
      .io_flush          (io_flush),
      .io_mul_resp_valid (io_mul_resp_valid),
      .io_mul_resp_data  (io_mul_resp_data),
      .io_mul_resp_ready (io_mul_resp_ready),
      .io_wb_valid       (io_wb_valid),
      .io_wb_tag         (io_wb_tag),
      .io_wb_data        (io_wb_data),
      .io_wb_ready       (io_wb_ready),
      .io_count          (io_count),
      .io_busy           (io_busy),
      .io_err            (io_err)
   );

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } ent_t;

   ent_t             mq[$];
   bit               m_pv;
   logic [TAG_W-1:0] m_tag;
   bit               m_err;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string name, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Reference behaviour for one clock edge, from the inputs held at the edge.
   task automatic model_edge();
      bit   hs, done, enq, legal, taken;
      ent_t e;
      if (reset) begin
         mq.delete();
         m_pv  = 0;
         m_tag = '0;
         m_err = 0;
         return;
      end
      hs    = io_mul_resp_valid && (mq.size() < DEPTH);
      done  = hs && m_pv;
      enq   = done && !io_kill && !io_flush;
      legal = !m_pv || done || io_kill || io_flush;
      e.tag  = m_tag;
      e.data = io_mul_resp_data;
      if (io_req_fire && !legal) m_err = 1;
      if (hs && !m_pv && !io_kill && !io_flush) m_err = 1;
      if (io_flush) begin
         mq.delete();
      end else begin
         taken = 0;
`ifdef MULDIV_WB_BYPASS_EN
         if (mq.size() == 0 && enq && io_wb_ready) taken = 1;
`endif
         if (!taken) begin
            if (io_wb_ready && mq.size() > 0) void'(mq.pop_front());
            if (enq) mq.push_back(e);
         end
      end
      if (io_req_fire && legal) begin
         m_pv  = 1;
         m_tag = io_req_tag;
      end else if (!io_req_fire && (done || io_kill || io_flush)) begin
         m_pv = 0;
      end
   endtask

   task automatic check_all();
      logic             e_valid;
      logic [TAG_W-1:0] e_tag;
      logic [XLEN-1:0]  e_data;
      e_valid = 0;
      e_tag   = '0;
      e_data  = '0;
      if (mq.size() > 0) begin
         e_valid = 1;
         e_tag   = mq[0].tag;
         e_data  = mq[0].data;
      end
`ifdef MULDIV_WB_BYPASS_EN
      else if (!reset && io_mul_resp_valid && m_pv && !io_kill && !io_flush) begin
         e_valid = 1;
         e_tag   = m_tag;
         e_data  = io_mul_resp_data;
      end
`endif
      cmp("resp_ready", 64'(io_mul_resp_ready), 64'(mq.size() < DEPTH));
      cmp("wb_valid", 64'(io_wb_valid), 64'(e_valid));
      cmp("wb_tag", 64'(io_wb_tag), 64'(e_tag));
      cmp("wb_data", io_wb_data, e_data);
      cmp("count", 64'(io_count), 64'(mq.size()));
      cmp("busy", 64'(io_busy), 64'(m_pv));
      cmp("err", 64'(io_err), 64'(m_err));
   endtask

   task automatic apply(input bit rst, input bit fire,
                        input logic [TAG_W-1:0] tg, input bit kill,
                        input bit fl, input bit rv,
                        input logic [XLEN-1:0] d, input bit wbr);
      @(posedge clock);
      model_edge();
      @(negedge clock);
      reset             = rst;
      io_req_fire       = fire;
      io_req_tag        = tg;
      io_kill           = kill;
      io_flush          = fl;
      io_mul_resp_valid = rv;
      io_mul_resp_data  = d;
      io_wb_ready       = wbr;
      #1;
      check_all();
   endtask

   task automatic do_reset();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit               rv, fire, kill, fl, wbr;
      logic [TAG_W-1:0] tg;
      logic [XLEN-1:0]  d;

      // Reset state
      do_reset();
      cmp("rst_resp_ready", 64'(io_mul_resp_ready), 64'd1);
      cmp("rst_wb_valid", 64'(io_wb_valid), 64'd0);
      cmp("rst_count", 64'(io_count), 64'd0);
      cmp("rst_err", 64'(io_err), 64'd0);

      // Basic single op
      apply(0, 1, 6'h05, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("basic_busy", 64'(io_busy), 64'd1);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 1, 64'h2A, 1);
`ifdef MULDIV_WB_BYPASS_EN
      cmp("basic_byp_valid", 64'(io_wb_valid), 64'd1);
      cmp("basic_byp_tag", 64'(io_wb_tag), 64'h05);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("basic_byp_cnt", 64'(io_count), 64'd0);
`else
      cmp("basic_lat_valid", 64'(io_wb_valid), 64'd0);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("basic_valid", 64'(io_wb_valid), 64'd1);
      cmp("basic_tag", 64'(io_wb_tag), 64'h05);
      cmp("basic_data", io_wb_data, 64'h2A);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("basic_valid_off", 64'(io_wb_valid), 64'd0);
      cmp("basic_cnt", 64'(io_count), 64'd0);
`endif

      // Backpressure and ordering
      do_reset();
      apply(0, 1, 6'h01, 0, 0, 0, 0, 0);
      apply(0, 1, 6'h02, 0, 0, 1, 64'h11, 0);
      apply(0, 0, 0, 0, 0, 1, 64'h22, 0);
      apply(0, 1, 6'h03, 0, 0, 0, 0, 0);
      cmp("bp_count", 64'(io_count), 64'd2);
      cmp("bp_ready", 64'(io_mul_resp_ready), 64'd0);
      apply(0, 0, 0, 0, 0, 1, 64'h33, 0);
      cmp("bp_stall_cnt", 64'(io_count), 64'd2);
      cmp("bp_stall_busy", 64'(io_busy), 64'd1);
      apply(0, 0, 0, 0, 0, 1, 64'h33, 1);
      cmp("bp_pop1_tag", 64'(io_wb_tag), 64'h01);
      cmp("bp_pop1_data", io_wb_data, 64'h11);
      apply(0, 0, 0, 0, 0, 1, 64'h33, 1);
      cmp("bp_pop2_tag", 64'(io_wb_tag), 64'h02);
      cmp("bp_pop2_ready", 64'(io_mul_resp_ready), 64'd1);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("bp_pop3_tag", 64'(io_wb_tag), 64'h03);
      apply(0, 0, 0, 0, 0, 0, 0, 1);

      // Kill racing the response
      do_reset();
      apply(0, 1, 6'h07, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 1, 0, 1, 64'h77, 1);
      cmp("kill_byp_valid", 64'(io_wb_valid), 64'd0);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("kill_busy", 64'(io_busy), 64'd0);
      cmp("kill_err", 64'(io_err), 64'd0);
      cmp("kill_count", 64'(io_count), 64'd0);

      // Flush with queued entries and an op in flight
      do_reset();
      apply(0, 1, 6'h01, 0, 0, 0, 0, 0);
      apply(0, 1, 6'h02, 0, 0, 1, 64'hA1, 0);
      apply(0, 1, 6'h03, 0, 0, 1, 64'hA2, 0);
      apply(0, 0, 0, 0, 1, 0, 0, 1);
      cmp("fl_pre_count", 64'(io_count), 64'd2);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      cmp("fl_count", 64'(io_count), 64'd0);
      cmp("fl_valid", 64'(io_wb_valid), 64'd0);
      cmp("fl_busy", 64'(io_busy), 64'd0);
      apply(0, 0, 0, 0, 0, 1, 64'hA3, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      cmp("fl_late_err", 64'(io_err), 64'd1);
      cmp("fl_late_count", 64'(io_count), 64'd0);

      // Double fire keeps the first tag
      do_reset();
      apply(0, 1, 6'h0A, 0, 0, 0, 0, 1);
      apply(0, 1, 6'h0B, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 1, 64'h55, 1);
      cmp("perr_err", 64'(io_err), 64'd1);
`ifdef MULDIV_WB_BYPASS_EN
      cmp("perr_tag", 64'(io_wb_tag), 64'h0A);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
`else
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("perr_tag", 64'(io_wb_tag), 64'h0A);
`endif

`ifdef MULDIV_WB_BYPASS_EN
      // Zero-latency bypass into a ready arbiter
      do_reset();
      apply(0, 1, 6'h03, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 1, 64'hFF, 1);
      cmp("byp_valid", 64'(io_wb_valid), 64'd1);
      cmp("byp_tag", 64'(io_wb_tag), 64'h03);
      cmp("byp_data", io_wb_data, 64'hFF);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("byp_count", 64'(io_count), 64'd0);
`endif

      // Random traffic, mostly protocol-legal, with periodic resets
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (i % 80 == 79) begin
            do_reset();
            continue;
         end
         rv   = ($urandom_range(0, 2) == 0);
         fire = ($urandom_range(0, 3) == 0) &&
                (!m_pv || rv || $urandom_range(0, 7) == 0);
         kill = ($urandom_range(0, 15) == 0);
         fl   = ($urandom_range(0, 39) == 0);
         wbr  = ($urandom_range(0, 1) == 0);
         tg   = TAG_W'($urandom);
         d    = {$urandom, $urandom};
         apply(0, fire, tg, kill, fl, rv, d, wbr);
      end
      apply(0, 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
